// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC field-arithmetic blocks: controller state
// encoding, the default operand width and the secp256k1 field prime.
package ecc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 256;

  // secp256k1 field prime p = 2^256 - 2^32 - 977
  localparam logic [255:0] SECP256K1_P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

endpackage

// File: rtl/modmul_step.sv
// One lane of MSB-first interleaved modular multiplication:
// acc' = (2*acc + bit*a) mod m, using WIDTH+1-bit intermediates so that
// moduli up to 2^WIDTH-1 are handled (the extra bit carries the overflow).
module modmul_step
  import ecc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_m,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_acc
);

  logic [WIDTH:0]   w_m_ext;
  logic [WIDTH:0]   w_dbl;
  logic [WIDTH-1:0] w_red1;
  logic [WIDTH:0]   w_sum;

  assign w_m_ext = {1'b0, i_m};
  assign w_dbl   = {i_acc, 1'b0};

  // After each conditional subtract the value is below m, so it fits WIDTH bits.
  assign w_red1 = (w_dbl >= w_m_ext) ? WIDTH'(w_dbl - w_m_ext) : w_dbl[WIDTH-1:0];
  assign w_sum  = i_bit ? ({1'b0, w_red1} + {1'b0, i_a}) : {1'b0, w_red1};
  assign o_acc  = (w_sum >= w_m_ext) ? WIDTH'(w_sum - w_m_ext) : w_sum[WIDTH-1:0];

endmodule

// File: rtl/modmul_lanes.sv
// Multi-lane modular multiplier: p[i] = a[i] * b mod m for LANES lanes that
// share b and m. One bit of b is consumed per cycle, MSB first, all lanes in
// lock-step. Optional macro MODMUL_LANES_EARLY_EXIT_EN skips the leading
// zeros of b at capture, shortening the run to the significant bits of b.
module modmul_lanes
  import ecc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int LANES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LANES*WIDTH-1:0] a,
  input  logic [WIDTH-1:0]       b,
  input  logic [WIDTH-1:0]       m,
  output logic [LANES*WIDTH-1:0] p,
  output logic                   busy,
  output logic                   done
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t                 r_state;
  state_t                 w_state_next;
  logic [CW-1:0]          r_cnt;
  logic [WIDTH-1:0]       r_b;
  logic [WIDTH-1:0]       r_m;
  logic [LANES*WIDTH-1:0] r_a;
  logic [LANES*WIDTH-1:0] r_acc;
  logic [LANES*WIDTH-1:0] r_p;
  logic [LANES*WIDTH-1:0] w_acc_step;
  logic [WIDTH-1:0]       w_b_init;
  logic [CW-1:0]          w_cnt_init;
  logic                   w_last;

`ifdef MODMUL_LANES_EARLY_EXIT_EN
  logic [CW-1:0] w_lz;

  // Leading-zero count of b. b=0 is clamped to WIDTH-1 so one zero step
  // still runs, giving a 2-cycle latency with p=0.
  always_comb begin
    w_lz = CW'(WIDTH - 1);
    for (int k = 0; k < WIDTH; k++) begin
      if (b[k]) w_lz = CW'(WIDTH - 1 - k);
    end
  end

  // Doubling a zero accumulator is a no-op, so leading zeros can be skipped.
  assign w_b_init   = b << w_lz;
  assign w_cnt_init = CW'(WIDTH) - w_lz;
`else
  assign w_b_init   = b;
  assign w_cnt_init = CW'(WIDTH);
`endif

  // Counter <= 1 also covers a corrupted 0 so the FSM can never stall in RUN.
  assign w_last = (r_cnt <= CW'(1));

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      modmul_step #(.WIDTH(WIDTH)) u_step (
        .i_acc (r_acc[gi*WIDTH +: WIDTH]),
        .i_a   (r_a[gi*WIDTH +: WIDTH]),
        .i_m   (r_m),
        .i_bit (r_b[WIDTH-1]),
        .o_acc (w_acc_step[gi*WIDTH +: WIDTH])
      );
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic: start is only honoured in IDLE.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Operand capture, per-cycle step, and result latch on the final step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_b   <= '0;
      r_m   <= '0;
      r_a   <= '0;
      r_acc <= '0;
      r_p   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_a   <= a;
            r_m   <= m;
            r_b   <= w_b_init;
            r_cnt <= w_cnt_init;
            r_acc <= '0;
          end
        end
        RUN: begin
          r_acc <= w_acc_step;
          r_b   <= r_b << 1;
          r_cnt <= r_cnt - CW'(1);
          if (w_last) r_p <= w_acc_step;
        end
        default: ;
      endcase
    end
  end

  assign p    = r_p;
  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);

endmodule
